// File: rtl/eff_sel_ctrl_if.sv
// eff_sel_ctrl_if: request/sample inputs and pipe-control outputs of the effect-selection sequencer
interface eff_sel_ctrl_if;
   logic        smp_vld;
   logic        req_next;
   logic        req_prev;
   logic        req_byp;
   logic        en_o;
   logic [15:0] sel_o;
   logic [3:0]  idx_o;
   logic [15:0] gain_o;
   logic        busy_o;
   modport master (
      output smp_vld, req_next, req_prev, req_byp,
      input  en_o, sel_o, idx_o, gain_o, busy_o
   );
   modport slave (
      input  smp_vld, req_next, req_prev, req_byp,
      output en_o, sel_o, idx_o, gain_o, busy_o
   );
endinterface

// File: rtl/eff_sel_ctrl.sv
// eff_sel_ctrl: click-free effect switching by fading gain out, switching sel/en, flushing, fading back in
module eff_sel_ctrl #(
   parameter int N_EFF     = 4,
   parameter int FADE_LEN  = 64,
   parameter int FLUSH_LEN = 8
) (
   input logic          clk,
   input logic          rst_n,
   eff_sel_ctrl_if.slave bus
);
   localparam int LG = $clog2(FADE_LEN);
   localparam int SH = 15 - LG;
   localparam int KW = LG + 1;
   localparam int FW = $clog2(FLUSH_LEN + 1);
   localparam logic [KW-1:0] KMAX    = KW'(FADE_LEN);
   localparam logic [FW-1:0] FMAX    = FW'(FLUSH_LEN - 1);
   localparam logic [3:0]    IDX_MAX = 4'(N_EFF - 1);
   localparam logic [15:0]   FL16    = 16'(FADE_LEN);
   typedef enum logic [2:0] {RUN, FADE_OUT, SWITCH, FLUSH, FADE_IN} state_t;
   state_t        state;
   logic [KW-1:0] k;
   logic [FW-1:0] fc;
   logic          pend;
   logic [1:0]    pend_dir;
   logic          pend_tog;
   logic [3:0]    idx;
   logic [15:0]   sel;
   logic          en;
   logic [15:0]   gain;
   logic          dir_up, dir_dn, acc, want;
   logic [KW-1:0] k_inc;
   logic [15:0]   k16, g_dn, g_up;
   logic [3:0]    idx_nx;
   // simultaneous next+prev cancel each other and are not a request on their own
   assign dir_up = bus.req_next & ~bus.req_prev;
   assign dir_dn = bus.req_prev & ~bus.req_next;
   assign acc    = dir_up | dir_dn | bus.req_byp;
   assign want   = pend | acc;
   assign k_inc  = k + 1'b1;
   assign k16    = 16'(k_inc);
   assign g_dn   = (FL16 - k16) << SH;
   assign g_up   = k16 << SH;
   always_comb begin
      idx_nx = pend_dir[0] ? (idx == IDX_MAX ? '0 : idx + 1'b1) :
               pend_dir[1] ? (idx == '0 ? IDX_MAX : idx - 1'b1) : idx;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= FADE_IN;
         k        <= '0;
         fc       <= '0;
         pend     <= 1'b0;
         pend_dir <= 2'b00;
         pend_tog <= 1'b0;
         idx      <= '0;
         sel      <= 16'h0001;
         en       <= 1'b1;
         gain     <= '0;
      end else begin
         if (state == SWITCH) begin
            pend     <= acc;
            pend_dir <= {dir_dn, dir_up};
            pend_tog <= bus.req_byp;
         end else begin
            pend     <= want;
            pend_dir <= (dir_up | dir_dn) ? {dir_dn, dir_up} : pend_dir;
            pend_tog <= pend_tog ^ bus.req_byp;
         end
         case (state)
            RUN: begin
               gain <= 16'h7FFF;
               if (want) begin
                  state <= FADE_OUT;
                  k     <= '0;
               end
            end
            FADE_OUT: if (bus.smp_vld) begin
               k    <= k_inc;
               gain <= g_dn;
               if (k_inc == KMAX) state <= SWITCH;
            end
            SWITCH: begin
               idx   <= idx_nx;
               sel   <= 16'(1) << idx_nx;
               en    <= en ^ pend_tog;
               fc    <= '0;
               state <= FLUSH;
            end
            FLUSH: if (bus.smp_vld) begin
               fc <= fc + 1'b1;
               if (fc == FMAX) begin
                  state <= want ? SWITCH : FADE_IN;
                  k     <= '0;
               end
            end
            FADE_IN: begin
               // abort mirrors k so the fade-out resumes from the current gain
               if (want) begin
                  state <= (k == '0) ? SWITCH : FADE_OUT;
                  k     <= KMAX - k;
               end else if (bus.smp_vld) begin
                  k     <= k_inc;
                  gain  <= (k_inc == KMAX) ? 16'h7FFF : g_up;
                  state <= (k_inc == KMAX) ? RUN : FADE_IN;
               end
            end
            default: state <= FADE_IN;
         endcase
      end
   end
   assign bus.en_o   = en;
   assign bus.sel_o  = sel;
   assign bus.idx_o  = idx;
   assign bus.gain_o = gain;
   assign bus.busy_o = (state != RUN);
endmodule

// File: tb/tb_eff_sel_ctrl.sv
// tb_eff_sel_ctrl: random request sequences checked against a per-sample gain/index model
module tb_eff_sel_ctrl;
   localparam int N    = 4;
   localparam int FL   = 64;
   localparam int FLU  = 8;
   localparam int STEP = 32768 / FL;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int exp_idx = 0;
   bit exp_en = 1'b1;
   eff_sel_ctrl_if bus();
   eff_sel_ctrl #(.N_EFF(N), .FADE_LEN(FL), .FLUSH_LEN(FLU)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic smp();
      repeat ($urandom_range(0, 3)) tick();
      bus.smp_vld = 1'b1;
      tick();
      bus.smp_vld = 1'b0;
   endtask
   task automatic pulse(input bit n, input bit p, input bit b);
      bus.req_next = n;
      bus.req_prev = p;
      bus.req_byp  = b;
      tick();
      bus.req_next = 1'b0;
      bus.req_prev = 1'b0;
      bus.req_byp  = 1'b0;
   endtask
   task automatic chk_reset();
      chk("rst_gain", bus.gain_o, 0);
      chk("rst_sel", bus.sel_o, 1);
      chk("rst_idx", bus.idx_o, 0);
      chk("rst_en", bus.en_o, 1);
      chk("rst_busy", bus.busy_o, 1);
   endtask
   task automatic fade_down(input int l);
      for (int j = 1; j <= l; j++) begin
         smp();
         chk("fade_out", bus.gain_o, (l - j) * STEP);
      end
   endtask
   task automatic fade_up(input int l);
      for (int j = 1; j <= l; j++) begin
         smp();
         chk("fade_in", bus.gain_o, (j == FL) ? 32'h7FFF : j * STEP);
      end
   endtask
   task automatic flush_chk(input int n);
      for (int j = 0; j < n; j++) begin
         smp();
         chk("flush_gain", bus.gain_o, 0);
      end
   endtask
   task automatic sw_chk(input int dir, input bit tog);
      chk("pre_sel", bus.sel_o, 32'(1) << exp_idx);
      chk("pre_en", bus.en_o, exp_en);
      exp_idx = (exp_idx + dir + N) % N;
      exp_en  = exp_en ^ tog;
      tick();
      chk("sw_idx", bus.idx_o, exp_idx);
      chk("sw_sel", bus.sel_o, 32'(1) << exp_idx);
      chk("sw_en", bus.en_o, exp_en);
      chk("sw_gain", bus.gain_o, 0);
   endtask
   task automatic full_seq(input bit n, input bit p, input bit b);
      pulse(n, p, b);
      chk("run_exit_gain", bus.gain_o, 32'h7FFF);
      chk("run_exit_busy", bus.busy_o, 1);
      fade_down(FL);
      sw_chk((n && !p) ? 1 : (p && !n) ? -1 : 0, b);
      flush_chk(FLU);
      fade_up(FL);
      chk("run_busy", bus.busy_o, 0);
   endtask
   initial begin
      bus.smp_vld  = 1'b0;
      bus.req_next = 1'b0;
      bus.req_prev = 1'b0;
      bus.req_byp  = 1'b0;
      repeat (3) tick();
      chk_reset();
      rst_n = 1'b1;
      fade_up(FL);
      chk("startup_busy", bus.busy_o, 0);
      chk("startup_sel", bus.sel_o, 1);
      chk("startup_en", bus.en_o, 1);
      full_seq(1, 0, 0);
      full_seq(1, 0, 0);
      full_seq(1, 0, 0);
      full_seq(1, 0, 0);
      full_seq(0, 1, 0);
      full_seq(1, 0, 1);
      full_seq(0, 0, 1);
      pulse(1, 1, 0);
      repeat (5) tick();
      chk("both_busy", bus.busy_o, 0);
      chk("both_gain", bus.gain_o, 32'h7FFF);
      chk("both_idx", bus.idx_o, exp_idx);
      pulse(0, 0, 1);
      pulse(0, 0, 1);
      chk("netzero_gain", bus.gain_o, 32'h7FFF);
      fade_down(FL);
      sw_chk(0, 0);
      flush_chk(FLU);
      fade_up(FL);
      pulse(1, 0, 0);
      fade_down(FL);
      sw_chk(1, 0);
      flush_chk(FLU);
      fade_up(16);
      pulse(1, 0, 0);
      chk("abort_hold", bus.gain_o, 32'h2000);
      fade_down(16);
      sw_chk(1, 0);
      flush_chk(FLU);
      fade_up(FL);
      pulse(1, 0, 0);
      fade_down(FL);
      sw_chk(1, 0);
      flush_chk(3);
      pulse(1, 0, 0);
      chk("flush_req_gain", bus.gain_o, 0);
      flush_chk(FLU - 3);
      sw_chk(1, 0);
      flush_chk(FLU);
      fade_up(FL);
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 4))
            0: full_seq(1, 0, 0);
            1: full_seq(0, 1, 0);
            2: full_seq(0, 0, 1);
            3: full_seq(1, 0, 1);
            default: full_seq(1, 1, 1);
         endcase
      end
      pulse(0, 1, 0);
      repeat (10) smp();
      rst_n = 1'b0;
      tick();
      chk_reset();
      rst_n = 1'b1;
      exp_idx = 0;
      exp_en = 1'b1;
      fade_up(FL);
      chk("rerun_busy", bus.busy_o, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
